rr_mux_arbiter: RTL



---
 rtl/rr_mux_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning the select of a shared mux2/4/8/16 datapath.
// Optional forced release after MAX_HOLD owned cycles: define ARB_TIMEOUT_EN.
module rr_mux_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] sel,
  output logic                     busy,
  output logic                     timeout
);

  localparam int unsigned SEL_W = $clog2(N_REQ);

  if (!(N_REQ == 2 || N_REQ == 4 || N_REQ == 8 || N_REQ == 16) ||
      MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_param_check
    $error("rr_mux_arbiter: illegal N_REQ/MAX_HOLD");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    BACKOFF = 2'd2
  } state_t;

  state_t             r_state, w_state_nx;
  logic [N_REQ-1:0]   r_grant, w_grant_nx;
  logic [SEL_W-1:0]   r_sel,   w_sel_nx;
  logic               r_busy,  w_busy_nx;
  logic [SEL_W-1:0]   r_ptr,   w_ptr_nx;

  logic [N_REQ-1:0]   w_cand;
  logic               w_found;
  logic [SEL_W-1:0]   w_winner;
  logic [SEL_W-1:0]   w_idx;
  logic               w_owner_req;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [N_REQ-1:0]   r_mask,    w_mask_nx;
  logic [7:0]         r_hold,    w_hold_nx;
  logic               r_timeout, w_timeout_nx;

  assign w_cand = req & ~r_mask;
`else
  assign w_cand = req;
`endif

  assign w_owner_req = req[r_sel];

  // Power-of-two N_REQ lets SEL_W-bit addition provide the wrap for free.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_ptr;
    w_idx    = r_ptr;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_idx = r_ptr + SEL_W'(k);
      if (!w_found && w_cand[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_grant_nx = r_grant;
    w_sel_nx   = r_sel;
    w_busy_nx  = r_busy;
    w_ptr_nx   = r_ptr;
`ifdef ARB_TIMEOUT_EN
    w_mask_nx    = r_mask & req;
    w_hold_nx    = r_hold;
    w_timeout_nx = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        w_grant_nx = '0;
        w_busy_nx  = 1'b0;
        if (w_found) begin
          w_grant_nx[w_winner] = 1'b1;
          w_sel_nx             = w_winner;
          w_busy_nx            = 1'b1;
          w_state_nx           = BUSY;
`ifdef ARB_TIMEOUT_EN
          w_hold_nx            = '0;
`endif
        end
      end
      BUSY: begin
        if (!w_owner_req) begin
          w_grant_nx = '0;
          w_busy_nx  = 1'b0;
          w_ptr_nx   = r_sel + SEL_W'(1);
          w_state_nx = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (r_hold == HOLD_LAST) begin
          w_grant_nx       = '0;
          w_busy_nx        = 1'b0;
          w_ptr_nx         = r_sel + SEL_W'(1);
          w_timeout_nx     = 1'b1;
          w_mask_nx[r_sel] = 1'b1;
          w_state_nx       = BACKOFF;
        end else begin
          w_hold_nx = r_hold + 8'd1;
        end
`endif
      end
      BACKOFF: begin
        w_grant_nx = '0;
        w_busy_nx  = 1'b0;
        w_state_nx = IDLE;
      end
      default: begin
        w_grant_nx = '0;
        w_busy_nx  = 1'b0;
        w_state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_sel   <= '0;
      r_busy  <= 1'b0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_grant <= w_grant_nx;
      r_sel   <= w_sel_nx;
      r_busy  <= w_busy_nx;
      r_ptr   <= w_ptr_nx;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask    <= '0;
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_mask    <= w_mask_nx;
      r_hold    <= w_hold_nx;
      r_timeout <= w_timeout_nx;
    end
  end

  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  assign grant = r_grant;
  assign sel   = r_sel;
  assign busy  = r_busy;

endmodule
